uart_rx: RTL

Receive half of the keychain's serial link. Recovers 8N1 UART bytes from the asynchronous computer→FPGA line (uart_rxd) and presents each byte as a one-cycle valid pulse to the keychain's message/key assembler. Runs in the 10 MHz fabric domain. The transmit side is a separate block.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_ff.sv | 25 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, framing constants and
// the bit-period helper used by both serial directions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchronizer for an asynchronous single-bit input,
// with a selectable reset value so an idle-high line reads idle.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RESET_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: majority-voted mid-bit sampling, one-cycle
// valid / frame-error pulses, re-armed for a start edge right after the stop vote.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       frame_err_out,
    output logic       busy_out
);

    localparam int CPB  = cycles_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
    localparam logic [CW-1:0] CNT_VOTE = CW'(HALF + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [2:0]    FL_DONE  = 3'(SYNC_STAGES);

    if (CPB < 8) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ_HZ / BAUD_RATE must be at least 8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_check
        $error("uart_rx: SYNC_STAGES must be in 2..4");
    end
    if (STOP_BITS != 1) begin : g_stop_check
        $error("uart_rx: only one stop bit is supported");
    end

    rx_state_t state;
    rx_state_t state_n;

    logic            rx_s;
    logic            rx_prev;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   bit_idx;
    logic [7:0]      shift;
    logic            s0;
    logic            s1;
    logic [2:0]      flush_cnt;
    logic            armed;

    logic            flushed;
    logic            start_edge;
    logic            at_last;
    logic            at_vote;
    logic            vote;

    sync_ff #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk_in),
        .rst_n(rst_in),
        .d    (rx_wire_in),
        .q    (rx_s)
    );

    // The preset synchronizer fakes a high level after reset; only a
    // genuine high seen once it has flushed may arm edge detection.
    assign flushed    = (flush_cnt == FL_DONE);
    assign start_edge = armed && rx_prev && !rx_s;
    assign at_last    = (cnt == CNT_LAST);
    assign at_vote    = (cnt == CNT_VOTE);
    assign vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign busy_out   = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start_edge) state_n = START;
            end
            START: begin
                if (at_vote && vote) state_n = IDLE;
                else if (at_last)    state_n = DATA;
            end
            DATA: begin
                if (at_last && bit_idx == IDX_LAST) state_n = STOP;
            end
            STOP: begin
                if (at_vote) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_prev       <= 1'b1;
            flush_cnt     <= '0;
            armed         <= 1'b0;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            s0            <= 1'b0;
            s1            <= 1'b0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            rx_prev       <= rx_s;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;

            if (!flushed)         flush_cnt <= flush_cnt + 3'd1;
            if (flushed && rx_s)  armed     <= 1'b1;

            if (state == IDLE || state_n == IDLE || at_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (cnt == CNT_S0) s0 <= rx_s;
            if (cnt == CNT_S1) s1 <= rx_s;

            if (state == START) bit_idx <= '0;
            if (state == DATA && at_last) bit_idx <= bit_idx + 1'b1;
            if (state == DATA && at_vote) shift <= {vote, shift[7:1]};

            if (state == STOP && at_vote) begin
                if (vote) begin
                    data_out  <= shift;
                    valid_out <= 1'b1;
                end else begin
                    frame_err_out <= 1'b1;
                end
            end
        end
    end

endmodule
